// File: rtl/warp_sequencer_if.sv
// Port bundle between the warp sequencer, the warp dispatcher, the instruction
// memory and the func_unit lanes.
interface warp_sequencer_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8
);
  logic                   start;
  logic [PC_WIDTH-1:0]    base_pc;
  logic [NUM_THREADS-1:0] thread_mask;
  logic                   abort;
  logic                   ready;
  logic                   done;
  logic                   err;
  logic [15:0]            instr_count;
  logic                   imem_rd;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [31:0]            imem_data;
  logic [2:0]             fu_type;
  logic [4:0]             fu_rs1;
  logic [4:0]             fu_rs2;
  logic [4:0]             fu_rd;
  logic [5:0]             fu_shammt;
  logic [NUM_THREADS-1:0] fu_active;
  logic [NUM_THREADS-1:0] fu_complete;

  modport master (
    input  start, base_pc, thread_mask, abort, imem_data, fu_complete,
    output ready, done, err, instr_count, imem_rd, imem_addr,
           fu_type, fu_rs1, fu_rs2, fu_rd, fu_shammt, fu_active
  );

  modport slave (
    output start, base_pc, thread_mask, abort, imem_data, fu_complete,
    input  ready, done, err, instr_count, imem_rd, imem_addr,
           fu_type, fu_rs1, fu_rs2, fu_rd, fu_shammt, fu_active
  );
endinterface

// File: rtl/warp_sequencer.sv
// Single-warp issue controller: fetch, decode and broadcast one instruction per
// three cycles to the func_unit lanes, then drain and report done.
module warp_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8,
  parameter int MAX_INSTR   = 255
) (
  input  logic             clk,
  input  logic             rst,
  warp_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]  T_HALT     = 3'b111;
  localparam logic [23:0] HALT_WORD  = {3'b111, 21'd0};
  localparam logic [15:0] LAST_COUNT = 16'(MAX_INSTR - 1);

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  // Decoded word: [23:21] type, [20:16] rd, [15:11] rs1, [10:6] rs2, [5:0] shammt
  logic [23:0]            instr_q, instr_d;
  logic [15:0]            count_q, count_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   imem_rd_q, imem_rd_d;
  logic [PC_WIDTH-1:0]    imem_addr_q, imem_addr_d;
  logic [2:0]             fu_type_q, fu_type_d;
  logic [NUM_THREADS-1:0] fu_active_q, fu_active_d;

  logic                   force_halt;
  logic [2:0]             fetched_type;
  logic [15:0]            count_inc;
  logic                   imem_unused;

  assign imem_unused  = ^bus.imem_data[7:0];
  assign force_halt   = (count_q == LAST_COUNT) && (bus.imem_data[31:29] != T_HALT);
  assign fetched_type = force_halt ? T_HALT : bus.imem_data[31:29];
  assign count_inc    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.base_pc;
          mask_d  = bus.thread_mask;
          count_d = 16'd0;
          err_d   = 1'b0;
          state_d = (bus.thread_mask != '0) ? S_FETCH : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          instr_d = HALT_WORD;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          instr_d = HALT_WORD;
        end else begin
          err_d   = err_q | force_halt;
          instr_d = {fetched_type, bus.imem_data[28:8]};
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        count_d = count_inc;
        pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        err_d   = err_q | bus.abort;
        // An abort on a non-halt issue turns straight into a synthetic halt issue
        if (instr_q[23:21] == T_HALT) begin
          state_d = S_DRAIN;
        end else if (bus.abort) begin
          instr_d = HALT_WORD;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        state_d = ((bus.fu_complete & mask_q) == mask_q) ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    imem_rd_d   = (state_d == S_FETCH);
    imem_addr_d = (state_d == S_FETCH) ? pc_d : imem_addr_q;
    fu_type_d   = (state_d == S_ISSUE) ? instr_d[23:21] : T_HALT;
    fu_active_d = (state_d == S_ISSUE) ? mask_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mask_q      <= '0;
      instr_q     <= 24'd0;
      count_q     <= 16'd0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      imem_rd_q   <= 1'b0;
      imem_addr_q <= '0;
      fu_type_q   <= 3'b111;
      fu_active_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      imem_rd_q   <= imem_rd_d;
      imem_addr_q <= imem_addr_d;
      fu_type_q   <= fu_type_d;
      fu_active_q <= fu_active_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;
  assign bus.imem_rd     = imem_rd_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.fu_type     = fu_type_q;
  assign bus.fu_rd       = instr_q[20:16];
  assign bus.fu_rs1      = instr_q[15:11];
  assign bus.fu_rs2      = instr_q[10:6];
  assign bus.fu_shammt   = instr_q[5:0];
  assign bus.fu_active   = fu_active_q;

endmodule

// File: tb/tb_warp_sequencer.sv
// Directed table-driven bench for warp_sequencer (built with MAX_INSTR=4) plus
// a hand-written reset-during-drain sequence.
module tb_warp_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  warp_sequencer_if #(.NUM_THREADS(4), .PC_WIDTH(8)) bus ();

  warp_sequencer #(.NUM_THREADS(4), .PC_WIDTH(8), .MAX_INSTR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous instruction memory model
  logic [31:0] mem [256];
  logic [31:0] mem_q;
  always @(posedge clk) if (bus.imem_rd) mem_q <= mem[bus.imem_addr];
  assign bus.imem_data = mem_q;

  typedef struct {
    logic [7:0]  bpc;
    logic [3:0]  mask;
    logic [3:0]  comp;
    logic [31:0] p0, p1, p2, p3;
    int          abort_fetch;
    int          drain_delay;
    bit          start_in_drain;
    int          exp_issues;
    int          exp_reads;
    int          exp_done;
    logic [15:0] exp_count;
    logic        exp_err;
    logic [2:0]  exp_last;
    logic [7:0]  exp_a0, exp_a1;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];
  vec_t v;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, n_iss, n_rd, n_done, done_cyc, post, stray, bad_act, bad_gap, last_iss, halt_cyc;
  bit abort_arm, found, done_seen;
  logic [2:0]  last_type;
  logic [20:0] first_fields;
  logic [7:0]  ra [2];
  logic [7:0]  a;
  logic [31:0] ADD, SUB, SHL, HALT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [5:0] sh);
    return {t, rd, rs1, rs2, sh, 8'hA5};
  endfunction

  function automatic vec_t mkv(input logic [7:0] bpc, input logic [3:0] mask, input logic [3:0] comp,
                               input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                               input logic [31:0] p3, input int abort_fetch, input int drain_delay,
                               input bit sid, input int ei, input int er, input int ed,
                               input logic [15:0] ec, input logic ee, input logic [2:0] el,
                               input logic [7:0] a0, input logic [7:0] a1);
    vec_t r;
    r.bpc = bpc; r.mask = mask; r.comp = comp;
    r.p0 = p0; r.p1 = p1; r.p2 = p2; r.p3 = p3;
    r.abort_fetch = abort_fetch; r.drain_delay = drain_delay; r.start_in_drain = sid;
    r.exp_issues = ei; r.exp_reads = er; r.exp_done = ed; r.exp_count = ec;
    r.exp_err = ee; r.exp_last = el; r.exp_a0 = a0; r.exp_a1 = a1;
    return r;
  endfunction

  initial begin
    ADD  = ins(3'b000, 5'd3, 5'd1, 5'd2, 6'd0);
    SUB  = ins(3'b001, 5'd4, 5'd3, 5'd1, 6'd5);
    SHL  = ins(3'b010, 5'd7, 5'd4, 5'd0, 6'd12);
    HALT = ins(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
    for (int k = 0; k < 256; k++) mem[k] = HALT;

    // bpc mask comp | program | abort drain sid | issues reads done count err last a0 a1
    vecs[0] = mkv(8'h08, 4'hF, 4'hF, ADD, SUB, HALT, ADD, 0, 0, 1'b0, 3, 3, 11, 16'd3, 1'b0, 3'b111, 8'h08, 8'h09);
    vecs[1] = mkv(8'h20, 4'h5, 4'h5, ADD, SUB, HALT, ADD, 0, 0, 1'b0, 3, 3, 11, 16'd3, 1'b0, 3'b111, 8'h20, 8'h21);
    vecs[2] = mkv(8'h40, 4'hF, 4'hF, ADD, SUB, SHL,  ADD, 0, 0, 1'b0, 4, 4, 14, 16'd4, 1'b1, 3'b111, 8'h40, 8'h41);
    vecs[3] = mkv(8'h60, 4'h0, 4'h0, ADD, SUB, HALT, ADD, 0, 0, 1'b0, 0, 0, 1,  16'd0, 1'b0, 3'b111, 8'h00, 8'h00);
    vecs[4] = mkv(8'h10, 4'hF, 4'hF, ADD, SUB, HALT, ADD, 2, 3, 1'b1, 2, 2, 10, 16'd2, 1'b1, 3'b111, 8'h10, 8'h11);
    vecs[5] = mkv(8'hFF, 4'hF, 4'hF, SHL, HALT, ADD, ADD, 0, 0, 1'b0, 2, 2, 8,  16'd2, 1'b0, 3'b111, 8'hFF, 8'h00);

    rst = 1'b1;
    bus.start = 1'b0; bus.base_pc = 8'h00; bus.thread_mask = 4'h0;
    bus.abort = 1'b0; bus.fu_complete = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_count", bus.instr_count, 16'd0);
    chk("rst_imem_rd", bus.imem_rd, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 8'h00);
    chk("rst_fu_type", bus.fu_type, 3'b111);
    chk("rst_fu_active", bus.fu_active, 4'h0);
    chk("rst_fu_fields", {bus.fu_rd, bus.fu_rs1, bus.fu_rs2, bus.fu_shammt}, 21'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      a = v.bpc;           mem[a] = v.p0;
      a = v.bpc + 8'd1;    mem[a] = v.p1;
      a = v.bpc + 8'd2;    mem[a] = v.p2;
      a = v.bpc + 8'd3;    mem[a] = v.p3;
      bus.fu_complete = 4'h0;
      bus.abort = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.base_pc = v.bpc; bus.thread_mask = v.mask;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1; n_iss = 0; n_rd = 0; n_done = 0; done_cyc = 0; post = 0;
      stray = 0; bad_act = 0; bad_gap = 0; last_iss = 0; halt_cyc = -1;
      abort_arm = 1'b0; last_type = 3'b000; first_fields = 21'd0;
      ra[0] = 8'h00; ra[1] = 8'h00;
      while (cyc < 80 && !(n_done > 0 && post >= 3)) begin
        if (bus.imem_rd) begin
          if (n_rd < 2) ra[n_rd] = bus.imem_addr;
          n_rd++;
        end
        if (bus.fu_active != 4'h0) begin
          if (n_iss > 0 && cyc - last_iss != 3) bad_gap++;
          if (bus.fu_active != v.mask) bad_act++;
          if (n_iss == 0) first_fields = {bus.fu_rd, bus.fu_rs1, bus.fu_rs2, bus.fu_shammt};
          last_type = bus.fu_type;
          last_iss = cyc;
          n_iss++;
          if (bus.fu_type == 3'b111) halt_cyc = cyc;
        end else if (bus.fu_type != 3'b111) begin
          stray++;
        end
        if (n_done > 0) post++;
        if (bus.done) begin
          n_done++;
          if (done_cyc == 0) done_cyc = cyc;
        end
        // Abort lands in the WAIT cycle following the targeted fetch
        bus.abort = abort_arm;
        abort_arm = bus.imem_rd && (n_rd == v.abort_fetch);
        if (halt_cyc > 0 && cyc >= halt_cyc + v.drain_delay) bus.fu_complete = v.comp;
        if (v.start_in_drain && halt_cyc > 0 && cyc == halt_cyc + 1) begin
          bus.start = 1'b1; bus.base_pc = 8'h00; bus.thread_mask = 4'hF;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk($sformatf("v%0d_done_pulses", i), n_done, 1);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, v.exp_done);
      chk($sformatf("v%0d_issues", i), n_iss, v.exp_issues);
      chk($sformatf("v%0d_reads", i), n_rd, v.exp_reads);
      chk($sformatf("v%0d_bad_active", i), bad_act, 0);
      chk($sformatf("v%0d_bad_spacing", i), bad_gap, 0);
      chk($sformatf("v%0d_stray_type", i), stray, 0);
      chk($sformatf("v%0d_instr_count", i), bus.instr_count, v.exp_count);
      chk($sformatf("v%0d_err", i), bus.err, v.exp_err);
      chk($sformatf("v%0d_ready", i), bus.ready, 1'b1);
      if (v.exp_issues > 0) begin
        chk($sformatf("v%0d_last_type", i), last_type, v.exp_last);
        chk($sformatf("v%0d_first_fields", i), first_fields, v.p0[28:8]);
      end
      if (v.exp_reads >= 2) begin
        chk($sformatf("v%0d_addr0", i), ra[0], v.exp_a0);
        chk($sformatf("v%0d_addr1", i), ra[1], v.exp_a1);
      end
    end

    // Reset asserted while draining: outputs return to reset values, no done
    mem[8'h50] = ADD;
    mem[8'h51] = HALT;
    bus.fu_complete = 4'h0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_pc = 8'h50; bus.thread_mask = 4'hF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      @(posedge clk); #1;
      if (bus.fu_active != 4'h0 && bus.fu_type == 3'b111) found = 1'b1;
    end
    chk("rstdrain_halt_seen", found, 1'b1);
    @(posedge clk); #1;
    chk("rstdrain_ready_busy", bus.ready, 1'b0);
    chk("rstdrain_active_off", bus.fu_active, 4'h0);
    rst = 1'b1;
    #1;
    chk("rstdrain_ready", bus.ready, 1'b1);
    chk("rstdrain_fu_active", bus.fu_active, 4'h0);
    chk("rstdrain_count", bus.instr_count, 16'd0);
    chk("rstdrain_done", bus.done, 1'b0);
    @(negedge clk) rst = 1'b0;
    bus.fu_complete = 4'hF;
    done_seen = 1'b0;
    for (int w = 0; w < 6; w++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    chk("rstdrain_no_done", done_seen, 1'b0);
    chk("rstdrain_idle", bus.ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
